// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared types and defaults for the FIR coefficient-bank controller
//   state_t   - controller state encoding (IDLE=0, LOAD=1, WAIT=2, ACC=3, SUM=4)
//   DEF_*     - default parameter values
//   totalTaps - total coefficient count across all banks
package fir_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WAIT = 3'd2,
        ACC  = 3'd3,
        SUM  = 3'd4
    } state_t;
    localparam int DEF_NUM_BANK      = 4;
    localparam int DEF_TAPS_PER_BANK = 10;
    localparam int DEF_COEFF_W       = 16;
    localparam int DEF_ADDR_W        = 4;
    localparam int DEF_IDX_W         = 6;
    function automatic int totalTaps(input int numBank, input int tapsPerBank);
        return numBank * tapsPerBank;
    endfunction
endpackage

// File: rtl/fir_coeff_decode.sv
// fir_coeff_decode: maps a global coefficient index to a bank and an in-bank address
//   idx     in  IDX_W     global coefficient index
//   bankSel out NUM_BANK  one-hot bank select, all zero when out of range
//   addr    out ADDR_W    address inside the selected bank, zero when out of range
//   inRange out 1         idx < NUM_BANK*TAPS_PER_BANK
module fir_coeff_decode
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_BANK      = DEF_NUM_BANK,
    parameter int TAPS_PER_BANK = DEF_TAPS_PER_BANK,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int IDX_W         = DEF_IDX_W
) (
    input  logic [IDX_W-1:0]    idx,
    output logic [NUM_BANK-1:0] bankSel,
    output logic [ADDR_W-1:0]   addr,
    output logic                inRange
);
    // Range compares against each bank window replace a divider and modulo.
    always_comb begin
        bankSel = '0;
        addr    = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (int'(idx) >= b * TAPS_PER_BANK && int'(idx) < (b + 1) * TAPS_PER_BANK) begin
                bankSel[b] = 1'b1;
                addr       = ADDR_W'(int'(idx) - b * TAPS_PER_BANK);
            end
        end
    end
    assign inRange = int'(idx) < totalTaps(NUM_BANK, TAPS_PER_BANK);
endmodule

// File: rtl/fir_bank_seq_ctrl.sv
// fir_bank_seq_ctrl: sequences coefficient load, per-sample tap sweep and sum strobe over NUM_BANK SRAMs
//   iClk_12M, iRst          clock, asynchronous active-high reset
//   iCoeffUpdate            level request for coefficient-load mode
//   iCoeffWrEn/Idx/Data     coefficient write port (honoured in LOAD only)
//   iSampleValid            new sample available; oSampleReady accepts it
//   oCsnRam/oWrnRam         per-bank active-low chip select / write enable
//   oAddrRam/oWrDtRam       per-bank address / write data, flattened, bank0 in LSBs
//   oEnAcc                  per-bank accumulator enable (read strobe delayed one cycle)
//   oEnDelay                sample delay-line enable
//   oSumValid               one-cycle pulse, filter output valid
//   oCoeffErr               one-cycle pulse after an out-of-range coefficient write
//   oState                  current state, for debug
//   oCoeffChk               XOR checksum of in-range writes, only with FIR_COEFF_CHKSUM_EN defined
module fir_bank_seq_ctrl #(
    parameter int NUM_BANK      = fir_ctrl_pkg::DEF_NUM_BANK,
    parameter int TAPS_PER_BANK = fir_ctrl_pkg::DEF_TAPS_PER_BANK,
    parameter int COEFF_W       = fir_ctrl_pkg::DEF_COEFF_W,
    parameter int ADDR_W        = fir_ctrl_pkg::DEF_ADDR_W,
    parameter int IDX_W         = fir_ctrl_pkg::DEF_IDX_W
) (
    input  logic                         iClk_12M,
    input  logic                         iRst,
    input  logic                         iCoeffUpdate,
    input  logic                         iCoeffWrEn,
    input  logic [IDX_W-1:0]             iCoeffIdx,
    input  logic [COEFF_W-1:0]           iCoeffData,
    input  logic                         iSampleValid,
    output logic                         oSampleReady,
    output logic [NUM_BANK-1:0]          oCsnRam,
    output logic [NUM_BANK-1:0]          oWrnRam,
    output logic [NUM_BANK*ADDR_W-1:0]   oAddrRam,
    output logic [NUM_BANK*COEFF_W-1:0]  oWrDtRam,
    output logic [NUM_BANK-1:0]          oEnAcc,
    output logic                         oEnDelay,
    output logic                         oSumValid,
    output logic                         oCoeffErr,
    output logic [2:0]                   oState
`ifdef FIR_COEFF_CHKSUM_EN
    ,
    output logic [COEFF_W-1:0]           oCoeffChk
`endif
);
    import fir_ctrl_pkg::*;

    state_t                state;
    logic [ADDR_W-1:0]     tapCnt;
    logic [NUM_BANK-1:0]   decBank;
    logic [ADDR_W-1:0]     decAddr;
    logic                  decInRange;
    logic                  loadWr;
    logic                  tapLast;

    fir_coeff_decode #(
        .NUM_BANK      (NUM_BANK),
        .TAPS_PER_BANK (TAPS_PER_BANK),
        .ADDR_W        (ADDR_W),
        .IDX_W         (IDX_W)
    ) uDecode (
        .idx     (iCoeffIdx),
        .bankSel (decBank),
        .addr    (decAddr),
        .inRange (decInRange)
    );

    assign loadWr       = state == LOAD && iCoeffWrEn;
    assign tapLast      = tapCnt == ADDR_W'(TAPS_PER_BANK - 1);
    assign oSampleReady = state == WAIT && !iCoeffUpdate;
    assign oEnDelay     = state == WAIT || state == ACC || state == SUM;
    assign oState       = state;

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            state     <= IDLE;
            tapCnt    <= '0;
            oEnAcc    <= '0;
            oSumValid <= 1'b0;
            oCoeffErr <= 1'b0;
        end else begin
            // Accumulators consume SRAM data one cycle after the read strobe.
            oEnAcc    <= {NUM_BANK{state == ACC}};
            oSumValid <= state == SUM;
            oCoeffErr <= loadWr && !decInRange;
            case (state)
                IDLE: if (iCoeffUpdate) state <= LOAD;
                LOAD: if (!iCoeffUpdate) state <= WAIT;
                WAIT: begin
                    if (iCoeffUpdate) begin
                        state <= LOAD;
                    end else if (iSampleValid) begin
                        state  <= ACC;
                        tapCnt <= '0;
                    end
                end
                ACC: begin
                    tapCnt <= tapCnt + 1'b1;
                    if (tapLast) state <= SUM;
                end
                SUM:     state <= WAIT;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIR_COEFF_CHKSUM_EN
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            oCoeffChk <= '0;
        end else if ((state == IDLE || state == WAIT) && iCoeffUpdate) begin
            oCoeffChk <= '0;
        end else if (loadWr && decInRange) begin
            oCoeffChk <= oCoeffChk ^ iCoeffData;
        end
    end
`endif

    // Coefficient writes are driven straight from the host inputs so the SRAM sees them this cycle.
    always_comb begin
        oCsnRam  = '1;
        oWrnRam  = '1;
        oAddrRam = '0;
        oWrDtRam = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (loadWr && decBank[b]) begin
                oCsnRam[b]                       = 1'b0;
                oWrnRam[b]                       = 1'b0;
                oAddrRam[b*ADDR_W +: ADDR_W]     = decAddr;
                oWrDtRam[b*COEFF_W +: COEFF_W]   = iCoeffData;
            end else if (state == ACC) begin
                oCsnRam[b]                       = 1'b0;
                oAddrRam[b*ADDR_W +: ADDR_W]     = tapCnt;
            end
        end
    end
endmodule
